// File: rtl/spu_pkg.sv
// Shared constants and types for the SPU result-forwarding stage.
package spu_pkg;

    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 7;
    localparam int NUM_STAGES = 7;
    localparam int LAT_W      = 3;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LAT_W-1:0]  ready;
    } result_entry_t;

    typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_t;

    // First stage at which an entry may be forwarded; 0 means 1, values past writeback clamp to it.
    function automatic int eff_ready(input logic [LAT_W-1:0] ready);
        if (ready == '0) return 1;
        if (int'(ready) > NUM_STAGES) return NUM_STAGES;
        return int'(ready);
    endfunction

endpackage

// File: rtl/spu_forward_unit_if.sv
// Bundle between the issue/register-table side and the forwarding stage.
interface spu_forward_unit_if;
    import spu_pkg::*;

    logic              res_valid_even, res_valid_odd;
    logic [ADDR_W-1:0] res_addr_even, res_addr_odd;
    logic [DATA_W-1:0] res_data_even, res_data_odd;
    logic [LAT_W-1:0]  res_ready_even, res_ready_odd;

    logic [ADDR_W-1:0] src_addr_ra_e, src_addr_rb_e, src_addr_rc_e, src_addr_ra_o, src_addr_rb_o;
    logic [DATA_W-1:0] rf_ra_e, rf_rb_e, rf_rc_e, rf_ra_o, rf_rb_o;
    logic [DATA_W-1:0] fwd_ra_e, fwd_rb_e, fwd_rc_e, fwd_ra_o, fwd_rb_o;
    logic              stall;

    logic [DATA_W-1:0] rt_even, rt_odd;
    logic [ADDR_W-1:0] rt_addr_even, rt_addr_odd;
    logic              reg_write_even, reg_write_odd;

    modport master (
        output res_valid_even, res_valid_odd, res_addr_even, res_addr_odd,
               res_data_even, res_data_odd, res_ready_even, res_ready_odd,
               src_addr_ra_e, src_addr_rb_e, src_addr_rc_e, src_addr_ra_o, src_addr_rb_o,
               rf_ra_e, rf_rb_e, rf_rc_e, rf_ra_o, rf_rb_o,
        input  fwd_ra_e, fwd_rb_e, fwd_rc_e, fwd_ra_o, fwd_rb_o, stall,
               rt_even, rt_odd, rt_addr_even, rt_addr_odd, reg_write_even, reg_write_odd
    );

    modport slave (
        input  res_valid_even, res_valid_odd, res_addr_even, res_addr_odd,
               res_data_even, res_data_odd, res_ready_even, res_ready_odd,
               src_addr_ra_e, src_addr_rb_e, src_addr_rc_e, src_addr_ra_o, src_addr_rb_o,
               rf_ra_e, rf_rb_e, rf_rc_e, rf_ra_o, rf_rb_o,
        output fwd_ra_e, fwd_rb_e, fwd_rc_e, fwd_ra_o, fwd_rb_o, stall,
               rt_even, rt_odd, rt_addr_even, rt_addr_odd, reg_write_even, reg_write_odd
    );

endinterface

// File: rtl/spu_fwd_select.sv
// Youngest-match search for one operand over all in-flight entries.
module spu_fwd_select
    import spu_pkg::*;
(
    input  result_entry_t [2*NUM_STAGES-1:0] entries,  // index 0 is youngest (stage 1 odd)
    input  logic [ADDR_W-1:0]                src_addr,
    input  logic [DATA_W-1:0]                rf_data,
    output logic [DATA_W-1:0]                data,
    output logic                             hit_ready,
    output logic                             hit_pending
);

    logic              hit;
    logic              fwdable;
    int                hit_stage;
    logic [DATA_W-1:0] hit_data;
    logic [LAT_W-1:0]  hit_lat;

    // Walk oldest to youngest so the last match written is the youngest one.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        hit       = 1'b0;
        hit_stage = 0;
        hit_data  = '0;
        hit_lat   = '0;
        for (int i = 2*NUM_STAGES-1; i >= 0; i--) begin
            if (entries[i].valid && entries[i].addr == src_addr) begin
                hit       = 1'b1;
                hit_stage = i/2 + 1;
                hit_data  = entries[i].data;
                hit_lat   = entries[i].ready;
            end
        end
        fwdable     = hit && (hit_stage >= eff_ready(hit_lat));
        hit_ready   = fwdable;
        hit_pending = hit && !fwdable;
        data        = fwdable ? hit_data : rf_data;
    end

endmodule

// File: rtl/spu_forward_unit.sv
// Result pipeline for both SPU issue pipes with operand forwarding, stall and writeback.
module spu_forward_unit
    import spu_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    spu_forward_unit_if.slave       bus
);

    result_entry_t                   stage_q [NUM_STAGES][2];
    result_entry_t [2*NUM_STAGES-1:0] search;
    result_entry_t                   wb_even, wb_odd;

    logic [ADDR_W-1:0] src  [5];
    logic [DATA_W-1:0] rf   [5];
    logic [DATA_W-1:0] fwd  [5];
    logic [4:0]        rdy;
    logic [4:0]        pend;

    // NOTE: the pipeline never freezes, so stall is not an input here; data is also cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stage_q[s][PIPE_EVEN] <= '0;
                stage_q[s][PIPE_ODD]  <= '0;
            end
        end else begin
            for (int s = NUM_STAGES-1; s > 0; s--) begin
                stage_q[s][PIPE_EVEN] <= flush ? '0 : stage_q[s-1][PIPE_EVEN];
                stage_q[s][PIPE_ODD]  <= flush ? '0 : stage_q[s-1][PIPE_ODD];
            end
            stage_q[0][PIPE_EVEN] <= flush ? '0 : result_entry_t'{bus.res_valid_even, bus.res_addr_even,
                                                                   bus.res_data_even, bus.res_ready_even};
            stage_q[0][PIPE_ODD]  <= flush ? '0 : result_entry_t'{bus.res_valid_odd, bus.res_addr_odd,
                                                                   bus.res_data_odd, bus.res_ready_odd};
        end
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_search
        assign search[2*s]   = stage_q[s][PIPE_ODD];
        assign search[2*s+1] = stage_q[s][PIPE_EVEN];
    end

    assign src = '{bus.src_addr_ra_e, bus.src_addr_rb_e, bus.src_addr_rc_e, bus.src_addr_ra_o, bus.src_addr_rb_o};
    assign rf  = '{bus.rf_ra_e, bus.rf_rb_e, bus.rf_rc_e, bus.rf_ra_o, bus.rf_rb_o};

    for (genvar k = 0; k < 5; k++) begin : g_sel
        spu_fwd_select u_sel (
            .entries     (search),
            .src_addr    (src[k]),
            .rf_data     (rf[k]),
            .data        (fwd[k]),
            .hit_ready   (rdy[k]),
            .hit_pending (pend[k])
        );
    end

    assign bus.fwd_ra_e = fwd[0];
    assign bus.fwd_rb_e = fwd[1];
    assign bus.fwd_rc_e = fwd[2];
    assign bus.fwd_ra_o = fwd[3];
    assign bus.fwd_rb_o = fwd[4];
    assign bus.stall    = |pend;

    assign wb_even = stage_q[NUM_STAGES-1][PIPE_EVEN];
    assign wb_odd  = stage_q[NUM_STAGES-1][PIPE_ODD];

    // Odd is younger, so it owns a same-address writeback.
    assign bus.reg_write_even = wb_even.valid && !(wb_odd.valid && wb_odd.addr == wb_even.addr);
    assign bus.reg_write_odd  = wb_odd.valid;
    assign bus.rt_even        = wb_even.valid ? wb_even.data : '0;
    assign bus.rt_odd         = wb_odd.valid  ? wb_odd.data  : '0;
    assign bus.rt_addr_even   = wb_even.valid ? wb_even.addr : '0;
    assign bus.rt_addr_odd    = wb_odd.valid  ? wb_odd.addr  : '0;

    logic unused_rdy;
    assign unused_rdy = ^rdy;

endmodule

// File: tb/tb_spu_forward_unit.sv
// Directed self-checking bench for spu_forward_unit.
module tb_spu_forward_unit;
    import spu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   passed = 0;

    spu_forward_unit_if bus ();

    spu_forward_unit dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        reset = 1'b0;
        bus.res_valid_even = 1'b0;
        bus.res_valid_odd  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic issue_even(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [LAT_W-1:0] r);
        bus.res_valid_even = 1'b1;
        bus.res_addr_even  = a;
        bus.res_data_even  = d;
        bus.res_ready_even = r;
    endtask

    task automatic issue_odd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [LAT_W-1:0] r);
        bus.res_valid_odd = 1'b1;
        bus.res_addr_odd  = a;
        bus.res_data_odd  = d;
        bus.res_ready_odd = r;
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    task automatic park_srcs();
        bus.src_addr_ra_e = 7'd100; bus.src_addr_rb_e = 7'd100; bus.src_addr_rc_e = 7'd100;
        bus.src_addr_ra_o = 7'd100; bus.src_addr_rb_o = 7'd100;
        bus.rf_ra_e = '0; bus.rf_rb_e = '0; bus.rf_rc_e = '0; bus.rf_ra_o = '0; bus.rf_rb_o = '0;
    endtask

    task automatic test_reset();
        int wr_seen;
        do_reset();
        bus.src_addr_ra_e = 7'd0;
        bus.rf_ra_e = 128'h55;
        #1;
        chk("reset_reg_write_even", bus.reg_write_even, 1'b0);
        chk("reset_reg_write_odd", bus.reg_write_odd, 1'b0);
        chk("reset_rt_even", bus.rt_even, '0);
        chk("reset_rt_addr_odd", bus.rt_addr_odd, '0);
        chk("reset_stall", bus.stall, 1'b0);
        chk("reset_fwd_ra_e", bus.fwd_ra_e, 128'h55);
        // Reset while an entry sits in stage 2.
        issue_even(7'd5, 128'hA, 3'd0);
        tick();
        idle();
        tick();
        bus.src_addr_ra_e = 7'd5;
        bus.rf_ra_e = 128'h77;
        #1;
        chk("midflight_fwd_before_reset", bus.fwd_ra_e, 128'hA);
        do_reset();
        chk("midflight_fwd_after_reset", bus.fwd_ra_e, 128'h77);
        chk("midflight_stall_after_reset", bus.stall, 1'b0);
        wr_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.reg_write_even) wr_seen++;
        end
        chk("midflight_no_writeback", wr_seen, 0);
        park_srcs();
    endtask

    task automatic test_ready_fwd();
        do_reset();
        issue_even(7'd7, 128'hC, 3'd2);
        tick();
        idle();
        bus.src_addr_ra_o = 7'd7;
        bus.rf_ra_o = '0;
        #1;
        chk("ready_stage1_stall", bus.stall, 1'b1);
        chk("ready_stage1_fwd", bus.fwd_ra_o, '0);
        for (int s = 2; s <= NUM_STAGES; s++) begin
            tick();
            chk($sformatf("ready_stage%0d_fwd", s), bus.fwd_ra_o, 128'hC);
            chk($sformatf("ready_stage%0d_stall", s), bus.stall, 1'b0);
        end
        tick();
        chk("ready_retired_fwd", bus.fwd_ra_o, '0);
        park_srcs();
    endtask

    task automatic test_youngest(input logic [LAT_W-1:0] odd_ready);
        do_reset();
        issue_even(7'd5, 128'hA, 3'd1);
        tick();
        idle();
        tick();
        issue_odd(7'd5, 128'hB, odd_ready);
        tick();
        idle();
        bus.src_addr_ra_e = 7'd5;
        bus.rf_ra_e = 128'hF;
        #1;
        if (odd_ready == 3'd1) begin
            chk("youngest_ready_fwd", bus.fwd_ra_e, 128'hB);
            chk("youngest_ready_stall", bus.stall, 1'b0);
        end else begin
            chk("youngest_pending_fwd", bus.fwd_ra_e, 128'hF);
            chk("youngest_pending_stall", bus.stall, 1'b1);
            tick();
            chk("youngest_pending_s2_fwd", bus.fwd_ra_e, 128'hF);
            chk("youngest_pending_s2_stall", bus.stall, 1'b1);
            tick();
            tick();
            chk("youngest_pending_s4_fwd", bus.fwd_ra_e, 128'hB);
            chk("youngest_pending_s4_stall", bus.stall, 1'b0);
        end
        park_srcs();
    endtask

    task automatic test_collision();
        do_reset();
        issue_even(7'd5, 128'hC, 3'd1);
        issue_odd(7'd5, 128'hB, 3'd1);
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();
        chk("collision_stage6_no_write", bus.reg_write_odd, 1'b0);
        tick();
        chk("collision_reg_write_even", bus.reg_write_even, 1'b0);
        chk("collision_reg_write_odd", bus.reg_write_odd, 1'b1);
        chk("collision_rt_odd", bus.rt_odd, 128'hB);
        chk("collision_rt_addr_odd", bus.rt_addr_odd, 7'd5);
    endtask

    task automatic test_wb_bypass();
        do_reset();
        issue_even(7'd7, 128'hC, 3'd0);
        tick();
        idle();
        for (int i = 0; i < 6; i++) tick();
        bus.src_addr_rb_e = 7'd7;
        bus.rf_rb_e = '0;
        #1;
        chk("bypass_fwd_rb_e", bus.fwd_rb_e, 128'hC);
        chk("bypass_reg_write_even", bus.reg_write_even, 1'b1);
        chk("bypass_rt_even", bus.rt_even, 128'hC);
        chk("bypass_rt_addr_even", bus.rt_addr_even, 7'd7);
        tick();
        chk("bypass_after_wb_fwd", bus.fwd_rb_e, '0);
        chk("bypass_after_wb_write", bus.reg_write_even, 1'b0);
        park_srcs();
    endtask

    task automatic test_flush();
        int wr_even;
        int wr_odd;
        do_reset();
        wr_even = 0;
        wr_odd  = 0;
        for (int e = 1; e <= 14; e++) begin
            idle();
            if (e == 1) issue_even(7'd1, 128'h11, 3'd1);
            if (e == 4) issue_odd(7'd2, 128'h22, 3'd1);
            if (e == 7) issue_even(7'd3, 128'h33, 3'd1);
            if (e == 8) begin
                flush = 1'b1;
                issue_even(7'd4, 128'h44, 3'd1);
                issue_odd(7'd4, 128'h45, 3'd1);
            end
            tick();
            idle();
            if (bus.reg_write_even) wr_even++;
            if (bus.reg_write_odd) wr_odd++;
            if (e == 7) begin
                chk("flush_pre_wb_write", bus.reg_write_even, 1'b1);
                chk("flush_pre_wb_addr", bus.rt_addr_even, 7'd1);
                chk("flush_pre_wb_data", bus.rt_even, 128'h11);
            end
        end
        chk("flush_even_write_count", wr_even, 1);
        chk("flush_odd_write_count", wr_odd, 0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.res_valid_even = 1'b0; bus.res_valid_odd = 1'b0;
        bus.res_addr_even = '0; bus.res_addr_odd = '0;
        bus.res_data_even = '0; bus.res_data_odd = '0;
        bus.res_ready_even = '0; bus.res_ready_odd = '0;
        park_srcs();
        test_reset();
        test_ready_fwd();
        test_youngest(3'd1);
        test_youngest(3'd4);
        test_collision();
        test_wb_bypass();
        test_flush();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
